inst_sequencer: RTL and testbench

//  Control end of the single-cycle datapath: generates the instruction address and

---
 rtl/inst_sequencer.sv | 119 +++++++++++
 tb/tb_inst_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_sequencer.sv
// rtl/inst_sequencer.sv - fetch/exec sequencer driving the instruction address and regfile write enable
module inst_sequencer #(
    parameter int ADDR_W    = 5,
    parameter int LAST_ADDR = 31,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_addr,
    output logic              reg_write,
    output logic              busy,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_WAIT,
        S_HALT
    } state_t;

    localparam logic [6:0]        OP_SYSTEM = 7'b1110011;
    localparam logic [6:0]        OP_REG    = 7'b0110011;
    localparam logic [6:0]        OP_IMM    = 7'b0010011;
    localparam logic [ADDR_W-1:0] LAST_PC   = ADDR_W'(LAST_ADDR);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               reg_write_q, reg_write_d;
    logic               busy_q, busy_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   retired_q, retired_d;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic       is_halt;
    logic       is_write;

    assign opcode   = inst[6:0];
    assign rd       = inst[11:7];
    assign is_halt  = (inst == 32'h0) || (opcode == OP_SYSTEM);
    assign is_write = ((opcode == OP_REG) || (opcode == OP_IMM)) && (rd != 5'd0);

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        reg_write_d = reg_write_q;
        retired_d   = retired_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start) begin
                    state_d   = S_FETCH;
                    pc_d      = '0;
                    retired_d = '0;
                end
            end
            S_FETCH: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    state_d     = S_EXEC;
                    reg_write_d = is_write;
                end
            end
            S_EXEC: begin
                reg_write_d = 1'b0;
                retired_d   = retired_q + CNT_W'(1);
                // the last word ends the program; the pc never wraps back to 0
                if (pc_q == LAST_PC) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = pc_q + ADDR_W'(1);
                    state_d = step_mode ? S_WAIT : S_FETCH;
                end
            end
            S_WAIT: begin
                if (step) begin
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC) || (state_d == S_WAIT);
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            reg_write_q <= 1'b0;
            busy_q      <= 1'b0;
            halted_q    <= 1'b0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            reg_write_q <= reg_write_d;
            busy_q      <= busy_d;
            halted_q    <= halted_d;
            retired_q   <= retired_d;
        end
    end

    assign inst_addr = pc_q;
    assign reg_write = reg_write_q;
    assign busy      = busy_q;
    assign halted    = halted_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_inst_sequencer.sv
// tb/tb_inst_sequencer.sv - scoreboard bench for inst_sequencer with a program-level reference model
module tb_inst_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [31:0] inst;
    logic [4:0]  inst_addr;
    logic        reg_write;
    logic        busy;
    logic        halted;
    logic [15:0] retired;

    logic [31:0] mem [32];

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic        rw;
        logic        busy;
        logic        halted;
        logic [15:0] ret;
    } obs_t;

    typedef struct packed {
        logic [4:0] addr;
        logic       wr;
    } ex_t;

    obs_t exp_q[$];
    ex_t  prog_q[$];
    int   halt_addr;
    int   final_ret;
    bit   halt_fetch;

    inst_sequencer #(.ADDR_W(5), .LAST_ADDR(31), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .step_mode (step_mode),
        .step      (step),
        .inst      (inst),
        .inst_addr (inst_addr),
        .reg_write (reg_write),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    assign inst = mem[inst_addr];

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation is compared.
    always @(negedge clk) begin
        if (rst && exp_q.size() > 0) begin
            obs_t e;
            obs_t a;
            e = exp_q.pop_front();
            a = '{addr: inst_addr, rw: reg_write, busy: busy, halted: halted, ret: retired};
            check("cycle{addr,rw,busy,halted,retired}", {8'h0, a}, {8'h0, e});
        end
    end

    function automatic bit ref_halt(input logic [31:0] w);
        return (w == 32'h0) || (w[6:0] == 7'b1110011);
    endfunction

    function automatic bit ref_write(input logic [31:0] w);
        return (w[6:0] == 7'b0110011 || w[6:0] == 7'b0010011) && (w[11:7] != 5'd0);
    endfunction

    // Reference: walk memory as a program and list what gets executed.
    task automatic model();
        int a;
        prog_q.delete();
        a = 0;
        forever begin
            if (ref_halt(mem[a])) begin
                halt_fetch = 1'b1;
                halt_addr  = a;
                break;
            end
            prog_q.push_back('{addr: 5'(a), wr: ref_write(mem[a])});
            if (a == 31) begin
                halt_fetch = 1'b0;
                halt_addr  = 31;
                break;
            end
            a++;
        end
        final_ret = prog_q.size() % 65536;
    endtask

    function automatic obs_t mk(input int a, input bit rw, input bit b, input bit h, input int k);
        return '{addr: 5'(a), rw: rw, busy: b, halted: h, ret: 16'(k)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            check("drain_timeout", 32'(exp_q.size()), 32'h0);
            exp_q.delete();
        end
    endtask

    // Runs the program in mem; stray start/step pulses are thrown in where they must be ignored.
    task automatic run_prog(input bit smode, input bit noise);
        model();
        step_mode = smode;
        do_start();
        for (int i = 0; i < prog_q.size(); i++) begin
            int a;
            a = int'(prog_q[i].addr);
            exp_q.push_back(mk(a, 1'b0, 1'b1, 1'b0, i));
            exp_q.push_back(mk(a, prog_q[i].wr, 1'b1, 1'b0, i));
            start = noise & $urandom_range(0, 1);
            step  = noise & $urandom_range(0, 1);
            tick();
            start = noise & $urandom_range(0, 1);
            step  = noise & $urandom_range(0, 1);
            tick();
            start = 1'b0;
            step  = 1'b0;
            if (smode && a != 31) begin
                int nw;
                nw = $urandom_range(1, 3);
                for (int j = 0; j < nw; j++) exp_q.push_back(mk(a + 1, 1'b0, 1'b1, 1'b0, i + 1));
                for (int j = 0; j < nw; j++) begin
                    step  = (j == nw - 1);
                    start = noise & $urandom_range(0, 1);
                    tick();
                end
                step  = 1'b0;
                start = 1'b0;
            end
        end
        if (halt_fetch) begin
            exp_q.push_back(mk(halt_addr, 1'b0, 1'b1, 1'b0, final_ret));
            start = noise & $urandom_range(0, 1);
            tick();
            start = 1'b0;
        end
        exp_q.push_back(mk(halt_addr, 1'b0, 1'b0, 1'b1, final_ret));
        exp_q.push_back(mk(halt_addr, 1'b0, 1'b0, 1'b1, final_ret));
        drain();
        step_mode = 1'b0;
    endtask

    function automatic logic [31:0] rand_word();
        logic [31:0] w;
        int r;
        r = $urandom_range(0, 99);
        w = $urandom;
        if (r < 35) w[6:0] = 7'b0110011;
        else if (r < 65) w[6:0] = 7'b0010011;
        else if (r < 92) w = w;
        else if (r < 96) w = 32'h00000073;
        else w = 32'h0;
        if (r % 5 == 0) w[11:7] = 5'd0;
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 32'h00000013;

        // reset state while rst is held low
        #3;
        check("rst_addr", 32'(inst_addr), 32'h0);
        check("rst_flags{rw,busy,halted}", {29'h0, reg_write, busy, halted}, 32'h0);
        check("rst_retired", 32'(retired), 32'h0);
        tick();
        rst = 1'b1;

        // free-run: ADD, ADDI x0, ECALL
        mem[0] = 32'h003100B3;
        mem[1] = 32'h00000013;
        mem[2] = 32'h00000073;
        run_prog(1'b0, 1'b0);

        // end of memory: 32 x ADDI x5,x5,1
        for (int i = 0; i < 32; i++) mem[i] = 32'h00128293;
        run_prog(1'b0, 1'b1);

        // step mode: 3 ADDs then ECALL, with ignored pulses outside WAIT
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        for (int i = 0; i < 3; i++) mem[i] = 32'h003100B3;
        mem[3] = 32'h00000073;
        run_prog(1'b1, 1'b1);

        // restart from HALT with retired=5, start pulses while busy
        for (int i = 0; i < 5; i++) mem[i] = 32'h003100B3;
        mem[5] = 32'h00000073;
        run_prog(1'b0, 1'b0);
        run_prog(1'b0, 1'b1);

        // zero word at address 0
        mem[0] = 32'h0;
        run_prog(1'b0, 1'b1);

        // randomized programs in both modes
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < 32; i++) mem[i] = rand_word();
            run_prog(1'($urandom_range(0, 1)), 1'b1);
        end

        // async reset in the EXEC cycle of a writing instruction at addr 4
        for (int i = 0; i < 4; i++) mem[i] = 32'h00000013;
        mem[4] = 32'h003100B3;
        mem[5] = 32'h00000073;
        do_start();
        for (int i = 0; i < 9; i++) tick();
        check("pre_rst_rw", 32'(reg_write), 32'h1);
        check("pre_rst_addr", 32'(inst_addr), 32'h4);
        check("pre_rst_retired", 32'(retired), 32'h4);
        #1 rst = 1'b0;
        #1;
        check("async_rst_rw", 32'(reg_write), 32'h0);
        check("async_rst_addr", 32'(inst_addr), 32'h0);
        check("async_rst_retired", 32'(retired), 32'h0);
        check("async_rst_busy_halted", {30'h0, busy, halted}, 32'h0);
        tick();
        rst = 1'b1;
        tick();
        check("idle_after_rst_busy", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
